trial_div_sieve: RTL and testbench
==================================

// Module: trial_div_sieve
// PURPOSE
//  Upstream sieve/controller for the 1024-bit restoring divider (divider = 2 cycles/bit, ~2050 cycles/op).
//  Accepts one prime candidate, trial-divides by 2 then odd d=3,5,7..MAX_DIVISOR via the divider's
//  start/ready/done port, and consumes the remainder. Reports composite (with factor), proven prime,
//  or survivor (passed sieve, for Miller-Rabin downstream).
// PARAMETERS
//  WIDTH        1024  candidate / divider operand width
//  DW           16    trial-divisor register width
//  MAX_DIVISOR  1021  largest odd trial divisor; must be odd, >=3, < 2**DW-2
// PORTS
//  sys_clk        in   1      single clock
//  sys_rst        in   1      asynchronous, active-high reset
//  cand_valid     in   1      candidate offered
//  cand_ready     out  1      = (state==IDLE), combinational
//  candidate      in   WIDTH  number under test, sampled when cand_valid&cand_ready
//  res_valid      out  1      verdict held until res_ready
//  res_ready      in   1      downstream accepts verdict
//  res_composite  out  1      1 = composite (or candidate<2)
//  res_prime      out  1      1 = proven prime (d*d > candidate reached)
//  res_factor     out  DW     smallest factor found; 0 if candidate<2 or not composite
//  div_start      out  1      one-cycle start pulse to divider
//  div_dividend   out  WIDTH  = latched candidate, stable from ISSUE until div_done
//  div_divisor    out  WIDTH  = zero-extended d, stable from ISSUE until div_done
//  div_remainder  in   WIDTH  divider remainder, valid in div_done cycle
//  div_done       in   1      divider one-cycle completion pulse
//  div_ready      in   1      divider idle (combinational from divider)
// BEHAVIOUR
//  Reset: state=IDLE, res_valid=0, res_composite=0, res_prime=0, res_factor=0, div_start=0,
//   d=3, operand regs=0; cand_ready=1 after reset deasserts. Reset mid-division drops the job;
//   sys_rst is shared with the divider, so no stale div_done is possible.
//  States: IDLE -> CHECK -> {ISSUE <-> WAIT} -> REPORT -> IDLE.
//  IDLE: on cand_valid: latch candidate, d<=3 -> CHECK.
//  CHECK (1 cycle): cand<2 -> composite=1,factor=0; cand==2|3 -> prime=1; cand[0]==0 -> composite=1,
//   factor=2; all three go to REPORT. Otherwise -> ISSUE.
//  ISSUE: d*d (2*DW bits, zero-extended) > cand -> prime=1 -> REPORT; else d>MAX_DIVISOR -> survivor
//   (composite=0, prime=0) -> REPORT; else wait for div_ready, then div_start=1 for exactly one cycle
//   -> WAIT. At most one division in flight.
//  WAIT: div_start=0; on div_done: div_remainder==0 -> composite=1, factor=d -> REPORT;
//   else d<=d+2 -> ISSUE. d held in DW+1 bits internally; no wrap-around.
//  REPORT: res_valid=1, fields stable; on res_ready -> IDLE, res_valid=0 next cycle.
//   res_valid&res_ready and new cand_valid in the same cycle: candidate is not taken until IDLE.
//  Exactly one of {composite, prime, neither} per verdict; res_composite and res_prime never both 1.
//  Latency (odd cand, k divisions): 2 + k*(div latency + 2) cycles to res_valid.
// STRUCTURE
//  prime_pkg: state enum, WIDTH/DW defaults, FIRST_ODD_DIVISOR=3.
//  Sub-module trial_divisor_gen: d counter (load 3, step +2), d*d>cand and d>MAX_DIVISOR compares.
//  Top: FSM, operand/verdict registers, divider handshake.
// TESTING (bench instantiates the divider as the real DUT partner)
//  cand=91 -> divisions by 3,5,7; res_composite=1, res_factor=7, res_prime=0.
//  cand=97 -> divisions by 3,5,7,9; 11*11>97 -> res_prime=1, res_factor=0.
//  cand=2 -> res_prime=1; cand=1 -> composite=1,factor=0; cand=1024 -> composite=1,factor=2; no div_start.
//  MAX_DIVISOR=31, cand=2**61-1 -> 15 divisions (3..31), survivor: composite=0, prime=0.
//  cand=91 with res_ready low 20 cycles -> res_valid and fields held, cand_ready=0; IDLE after accept.
//  sys_rst pulse during WAIT -> all outputs at reset values immediately; next cand=25 -> factor=5.

Source files
------------

// File: rtl/prime_pkg.sv
// Shared types and defaults for the trial-division sieve that feeds the wide restoring divider.
package prime_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_REPORT
  } state_t;

  localparam int WIDTH_DEF         = 1024;
  localparam int DW_DEF            = 16;
  localparam int FIRST_ODD_DIVISOR = 3;

endpackage

// File: rtl/trial_divisor_gen.sv
// Odd trial-divisor counter: loads 3, steps by 2, and flags d*d > candidate and d past the limit.
module trial_divisor_gen
  import prime_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DW          = DW_DEF,
  parameter int MAX_DIVISOR = 1021
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] cand,
  output logic [DW:0]      d,
  output logic             sq_gt,
  output logic             over_max
);

  logic [2*DW+1:0] sq;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      d <= (DW+1)'(FIRST_ODD_DIVISOR);
    end else if (load) begin
      d <= (DW+1)'(FIRST_ODD_DIVISOR);
    end else if (step) begin
      d <= d + (DW+1)'(2);
    end
  end

  // The extra counter bit keeps d*d and the limit compare exact without wrap-around.
  assign sq       = (2*DW+2)'(d) * (2*DW+2)'(d);
  assign sq_gt    = WIDTH'(sq) > cand;
  assign over_max = d > (DW+1)'(MAX_DIVISOR);

endmodule

// File: rtl/trial_div_sieve.sv
// Prime-candidate sieve: screens small cases, then trial-divides by odd d through the divider handshake.
module trial_div_sieve
  import prime_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DW          = DW_DEF,
  parameter int MAX_DIVISOR = 1021
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             cand_valid,
  output logic             cand_ready,
  input  logic [WIDTH-1:0] candidate,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_composite,
  output logic             res_prime,
  output logic [DW-1:0]    res_factor,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic [WIDTH-1:0] div_remainder,
  input  logic             div_done,
  input  logic             div_ready
);

  localparam logic [WIDTH-1:0] TWO   = WIDTH'(2);
  localparam logic [WIDTH-1:0] THREE = WIDTH'(3);

  state_t           state;
  logic [WIDTH-1:0] cand_q;
  logic [DW:0]      d;
  logic             sq_gt;
  logic             over_max;
  logic             d_load;
  logic             d_step;

  assign cand_ready   = (state == S_IDLE);
  assign div_dividend = cand_q;
  assign d_load       = (state == S_IDLE) && cand_valid;
  assign d_step       = (state == S_WAIT) && div_done && (div_remainder != '0);

  trial_divisor_gen #(
    .WIDTH       (WIDTH),
    .DW          (DW),
    .MAX_DIVISOR (MAX_DIVISOR)
  ) u_gen (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .load     (d_load),
    .step     (d_step),
    .cand     (cand_q),
    .d        (d),
    .sq_gt    (sq_gt),
    .over_max (over_max)
  );

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= S_IDLE;
      cand_q        <= '0;
      div_divisor   <= '0;
      div_start     <= 1'b0;
      res_valid     <= 1'b0;
      res_composite <= 1'b0;
      res_prime     <= 1'b0;
      res_factor    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cand_valid) begin
            cand_q        <= candidate;
            res_composite <= 1'b0;
            res_prime     <= 1'b0;
            res_factor    <= '0;
            state         <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (cand_q < TWO) begin
            res_composite <= 1'b1;
            res_valid     <= 1'b1;
            state         <= S_REPORT;
          end else if (cand_q == TWO || cand_q == THREE) begin
            res_prime <= 1'b1;
            res_valid <= 1'b1;
            state     <= S_REPORT;
          end else if (!cand_q[0]) begin
            res_composite <= 1'b1;
            res_factor    <= DW'(2);
            res_valid     <= 1'b1;
            state         <= S_REPORT;
          end else begin
            state <= S_ISSUE;
          end
        end
        // Past sqrt(candidate) proves primality; past the limit leaves a survivor for later tests.
        S_ISSUE: begin
          if (sq_gt) begin
            res_prime <= 1'b1;
            res_valid <= 1'b1;
            state     <= S_REPORT;
          end else if (over_max) begin
            res_valid <= 1'b1;
            state     <= S_REPORT;
          end else if (div_ready) begin
            div_divisor <= WIDTH'(d);
            div_start   <= 1'b1;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          div_start <= 1'b0;
          if (div_done) begin
            if (div_remainder == '0) begin
              res_composite <= 1'b1;
              res_factor    <= d[DW-1:0];
              res_valid     <= 1'b1;
              state         <= S_REPORT;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trial_div_sieve.sv
// Directed bench for trial_div_sieve paired with a behavioural fixed-latency divider.
module tb_trial_div_sieve;

  localparam int WIDTH = 1024;
  localparam int DW    = 16;
  localparam int MAXD  = 31;
  localparam int LAT   = 6;

  logic             sys_clk = 1'b0;
  logic             sys_rst;
  logic             cand_valid;
  logic             cand_ready;
  logic [WIDTH-1:0] candidate;
  logic             res_valid;
  logic             res_ready;
  logic             res_composite;
  logic             res_prime;
  logic [DW-1:0]    res_factor;
  logic             div_start;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic [WIDTH-1:0] div_remainder;
  logic             div_done;
  logic             div_ready;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  trial_div_sieve #(
    .WIDTH       (WIDTH),
    .DW          (DW),
    .MAX_DIVISOR (MAXD)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .cand_valid    (cand_valid),
    .cand_ready    (cand_ready),
    .candidate     (candidate),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_composite (res_composite),
    .res_prime     (res_prime),
    .res_factor    (res_factor),
    .div_start     (div_start),
    .div_dividend  (div_dividend),
    .div_divisor   (div_divisor),
    .div_remainder (div_remainder),
    .div_done      (div_done),
    .div_ready     (div_ready)
  );

  // Divider partner: LAT cycles after an accepted start, pulse done with dividend % divisor.
  logic             busy;
  int               cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  int               nstarts = 0;
  logic [15:0]      dlog [64];

  assign div_ready = !busy;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      busy          <= 1'b0;
      cnt           <= 0;
      div_done      <= 1'b0;
      div_remainder <= '0;
      a_q           <= '0;
      b_q           <= '0;
    end else begin
      div_done <= 1'b0;
      if (div_start && !busy) begin
        busy                 <= 1'b1;
        cnt                  <= LAT;
        a_q                  <= div_dividend;
        b_q                  <= div_divisor;
        dlog[nstarts % 64]   <= div_divisor[15:0];
        nstarts              <= nstarts + 1;
      end else if (busy) begin
        if (cnt == 1) begin
          busy          <= 1'b0;
          div_done      <= 1'b1;
          div_remainder <= a_q % b_q;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [WIDTH-1:0] c);
    int t = 0;
    while (!cand_ready && t < 100) begin
      @(negedge sys_clk);
      t++;
    end
    candidate  = c;
    cand_valid = 1'b1;
    @(negedge sys_clk);
    cand_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag);
    int t = 0;
    while (!res_valid && t < 20000) begin
      @(negedge sys_clk);
      t++;
    end
    chk({tag, "_res_valid"}, 64'(res_valid), 64'd1);
    chk({tag, "_exclusive"}, 64'(res_composite & res_prime), 64'd0);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge sys_clk);
    res_ready = 1'b0;
  endtask

  task automatic verdict(input string tag, input logic comp, input logic prm,
                         input logic [DW-1:0] fac, input int ndiv, input int start0);
    wait_res(tag);
    chk({tag, "_composite"}, 64'(res_composite), 64'(comp));
    chk({tag, "_prime"},     64'(res_prime),     64'(prm));
    chk({tag, "_factor"},    64'(res_factor),    64'(fac));
    chk({tag, "_ndiv"},      64'(nstarts - start0), 64'(ndiv));
  endtask

  initial begin
    int s0;
    sys_rst    = 1'b1;
    cand_valid = 1'b0;
    candidate  = '0;
    res_ready  = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    chk("rst_cand_ready", 64'(cand_ready), 64'd1);
    chk("rst_res_valid",  64'(res_valid),  64'd0);
    chk("rst_composite",  64'(res_composite), 64'd0);
    chk("rst_prime",      64'(res_prime),  64'd0);
    chk("rst_factor",     64'(res_factor), 64'd0);
    chk("rst_div_start",  64'(div_start),  64'd0);
    chk("rst_dividend",   div_dividend[63:0], 64'd0);
    chk("rst_divisor",    div_divisor[63:0],  64'd0);

    // 91 = 7 * 13: divisions by 3, 5, 7.
    s0 = nstarts;
    offer(WIDTH'(91));
    verdict("c91", 1'b1, 1'b0, 16'd7, 3, s0);
    chk("c91_d0", 64'(dlog[s0 % 64]),       64'd3);
    chk("c91_d1", 64'(dlog[(s0 + 1) % 64]), 64'd5);
    chk("c91_d2", 64'(dlog[(s0 + 2) % 64]), 64'd7);
    accept();

    // 97 prime: 3,5,7,9 tried, then 11*11 > 97.
    s0 = nstarts;
    offer(WIDTH'(97));
    verdict("c97", 1'b0, 1'b1, 16'd0, 4, s0);
    chk("c97_dlast", 64'(dlog[(s0 + 3) % 64]), 64'd9);
    accept();

    s0 = nstarts;
    offer(WIDTH'(2));
    verdict("c2", 1'b0, 1'b1, 16'd0, 0, s0);
    accept();

    s0 = nstarts;
    offer(WIDTH'(1));
    verdict("c1", 1'b1, 1'b0, 16'd0, 0, s0);
    accept();

    s0 = nstarts;
    offer(WIDTH'(1024));
    verdict("c1024", 1'b1, 1'b0, 16'd2, 0, s0);
    accept();

    // 2**61-1 survives every odd divisor up to 31.
    s0 = nstarts;
    offer((WIDTH'(1) << 61) - WIDTH'(1));
    verdict("m61", 1'b0, 1'b0, 16'd0, 15, s0);
    chk("m61_dlast", 64'(dlog[(s0 + 14) % 64]), 64'd31);
    accept();
    chk("m61_idle", 64'(cand_ready), 64'd1);

    // Verdict held while downstream stalls.
    s0 = nstarts;
    offer(WIDTH'(91));
    wait_res("hold");
    repeat (20) @(negedge sys_clk);
    chk("hold_res_valid",  64'(res_valid),     64'd1);
    chk("hold_composite",  64'(res_composite), 64'd1);
    chk("hold_factor",     64'(res_factor),    64'd7);
    chk("hold_cand_ready", 64'(cand_ready),    64'd0);
    accept();
    chk("hold_released",   64'(res_valid),     64'd0);
    chk("hold_idle",       64'(cand_ready),    64'd1);

    // Asynchronous reset while a division is outstanding.
    s0 = nstarts;
    offer(WIDTH'(97));
    begin
      int t = 0;
      while (nstarts == s0 && t < 100) begin
        @(negedge sys_clk);
        t++;
      end
    end
    chk("wrst_started", 64'(nstarts - s0), 64'd1);
    @(negedge sys_clk);
    #2 sys_rst = 1'b1;
    #1;
    chk("wrst_cand_ready", 64'(cand_ready), 64'd1);
    chk("wrst_res_valid",  64'(res_valid),  64'd0);
    chk("wrst_div_start",  64'(div_start),  64'd0);
    chk("wrst_dividend",   div_dividend[63:0], 64'd0);
    chk("wrst_factor",     64'(res_factor), 64'd0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    s0 = nstarts;
    offer(WIDTH'(25));
    verdict("c25", 1'b1, 1'b0, 16'd5, 2, s0);
    accept();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
